// File: rtl/game_io_pkg.sv
// Shared constants for the game I/O window: button event byte codes and
// the debounce state encoding.
package game_io_pkg;

  localparam int NUM_BTN = 2;

  localparam logic [7:0] BTN_NONE       = 8'h00;
  localparam logic [7:0] BTN_CW         = 8'h01;
  localparam logic [7:0] BTN_ACW        = 8'h02;
  localparam int         BTN_MISSED_BIT = 7;

  typedef enum logic [1:0] {
    DB_LOW       = 2'd0,
    DB_WAIT_HIGH = 2'd1,
    DB_HIGH      = 2'd2,
    DB_WAIT_LOW  = 2'd3
  } db_state_e;

endpackage

// File: rtl/button_debounce.sv
// Per-button synchroniser and debounce FSM; emits a one-cycle press pulse
// when the debounced level rises.
module button_debounce
  import game_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_e              state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt, cnt_inc;

  assign s       = sync_q[SYNC_STAGES-1];
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      state  <= DB_LOW;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      // Only a settled rise is an event; bouncing back into HIGH from WAIT_LOW is not.
      press  <= (state == DB_WAIT_HIGH) && (state_nxt == DB_HIGH);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      DB_LOW:
        if (s) begin
          state_nxt = DB_WAIT_HIGH;
          cnt_nxt   = CNT_ONE;
        end
      DB_WAIT_HIGH:
        if (!s) begin
          state_nxt = DB_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = DB_HIGH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt_inc;
        end
      DB_HIGH:
        if (!s) begin
          state_nxt = DB_WAIT_LOW;
          cnt_nxt   = CNT_ONE;
        end
      DB_WAIT_LOW:
        if (s) begin
          state_nxt = DB_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = DB_LOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt_inc;
        end
      default: begin
        state_nxt = DB_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_event_latch.sv
// Button input port: debounces bc/bac and latches one pending turn event
// as a status byte that a RAM-side read consumes.
module button_event_latch
  import game_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bc,
  input  logic       bac,
  input  logic       button_read,
  output logic [7:0] button_op
);

  logic [NUM_BTN-1:0] raw, press;
  logic               accepted, pending;
  logic [7:0]         op_nxt;

  assign raw = {bac, bc};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .btn  (raw[i]),
      .press(press[i])
    );
  end

  // Simultaneous presses are ambiguous and count as no press at all.
  assign accepted = press[0] ^ press[1];
  assign pending  = |button_op[1:0];

  always_comb begin
    op_nxt = button_op;
    if (accepted) begin
      op_nxt = press[0] ? BTN_CW : BTN_ACW;
      op_nxt[BTN_MISSED_BIT] = !button_read && (button_op[BTN_MISSED_BIT] || pending);
    end else if (button_read) begin
      op_nxt = BTN_NONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) button_op <= BTN_NONE;
    else        button_op <= op_nxt;
  end

endmodule

// File: tb/tb_button_event_latch.sv
// Directed scenarios plus random button/read traffic, checked every cycle
// against a run-length debounce model of the event byte.
module tb_button_event_latch;

  localparam int DB = 4;
  localparam int SY = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       bc = 1'b0, bac = 1'b0, button_read = 1'b0;
  logic [7:0] button_op;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  button_event_latch #(.DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SY)) dut (
    .clk        (clk),
    .reset      (reset),
    .bc         (bc),
    .bac        (bac),
    .button_read(button_read),
    .button_op  (button_op)
  );

  // Model: a level flips after DB consecutive opposite synchronised samples;
  // a rising flip becomes a press that the event byte sees one edge later.
  logic [7:0] m_op;
  logic [1:0] m_pend;
  bit         m_lvl[2];
  int         m_run[2];
  bit         m_sq[2][$];

  function automatic void m_reset();
    m_op   = 8'h00;
    m_pend = 2'b00;
    for (int b = 0; b < 2; b++) begin
      m_lvl[b] = 1'b0;
      m_run[b] = 0;
      m_sq[b].delete();
      repeat (SY) m_sq[b].push_back(1'b0);
    end
  endfunction

  function automatic void m_step(input logic c, input logic a, input logic r);
    logic [1:0] rawv;
    logic [1:0] nxt;
    bit         s;
    rawv = {a, c};
    nxt  = 2'b00;
    if (m_pend == 2'b01 || m_pend == 2'b10) begin
      if (r) m_op = {6'b0, m_pend};
      else   m_op = {m_op[7] | (m_op[1:0] != 2'b00), 5'b0, m_pend};
    end else if (r) begin
      m_op = 8'h00;
    end
    for (int b = 0; b < 2; b++) begin
      m_sq[b].push_back(rawv[b]);
      s = m_sq[b].pop_front();
      if (s != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == DB) begin
          m_lvl[b] = s;
          m_run[b] = 0;
          if (s) nxt[b] = 1'b1;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_pend = nxt;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive, take one edge, compare at the next negedge.
  task automatic step(input logic c, input logic a, input logic r);
    bc = c; bac = a; button_read = r;
    @(posedge clk);
    if (!reset) m_reset();
    else        m_step(c, a, r);
    @(negedge clk);
    chk("model", button_op, m_op);
  endtask

  task automatic hold(input logic c, input logic a, input int n);
    repeat (n) step(c, a, 1'b0);
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    chk("rst_op", button_op, 8'h00);
    chk("rst_x", {7'b0, $isunknown(button_op)}, 8'h00);
    reset = 1'b1;

    // 1. async reset mid-debounce, then a held button after release
    hold(1, 0, 7);
    chk("t1_press", button_op, 8'h01);
    hold(0, 0, 8);
    hold(1, 0, 3);
    #2 reset = 1'b0;
    #1 chk("t1_async", button_op, 8'h00);
    m_reset();
    step(1, 0, 0);
    step(1, 0, 0);
    reset = 1'b1;
    hold(1, 0, 6);
    chk("t1_rel_6", button_op, 8'h00);
    step(1, 0, 0);
    chk("t1_rel_7", button_op, 8'h01);

    // 2. bounce then exact latency
    step(0, 0, 1);
    hold(0, 0, 8);
    step(1, 0, 0); step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
    hold(1, 0, 6);
    chk("t2_bounce", button_op, 8'h00);
    step(1, 0, 0);
    chk("t2_lat", button_op, 8'h01);
    hold(0, 0, 10);
    chk("t2_release", button_op, 8'h01);

    // 3. overwrite sets missed, read clears all
    hold(0, 1, 10);
    chk("t3_over", button_op, 8'h82);
    step(0, 0, 1);
    chk("t3_clr", button_op, 8'h00);
    hold(0, 0, 8);

    // 4. simultaneous presses are discarded
    hold(1, 1, 10);
    chk("t4_both0", button_op, 8'h00);
    hold(0, 0, 8);
    hold(1, 0, 8);
    hold(0, 0, 8);
    chk("t4_cw", button_op, 8'h01);
    hold(1, 1, 10);
    chk("t4_both1", button_op, 8'h01);
    hold(0, 0, 8);

    // 5. read collides with an acw press pulse
    hold(0, 1, 6);
    chk("t5_pre", button_op, 8'h01);
    step(0, 1, 1);
    chk("t5_post", button_op, 8'h02);

    // 6. idle read
    step(0, 0, 1);
    step(0, 0, 1);
    chk("t6_idle", button_op, 8'h00);
    hold(0, 0, 8);

    // random traffic
    for (int seg = 0; seg < 300; seg++) begin
      int   len;
      logic c, a;
      len = $urandom_range(1, 9);
      c   = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 5) == 0) ? 1'b1 : ~c & 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) step(c, a, ($urandom_range(0, 7) == 0));
    end
    chk("end_x", {7'b0, $isunknown(button_op)}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
